// File: rtl/store_queue_ctrl.sv
// Purpose: in-order store queue that decodes SB/SH/SW into lane-aligned memory writes, with fence drain.
// Latency: one cycle from store acceptance to mem_valid; no same-cycle bypass from request to memory.
// Backpressure: req_ready drops when the queue is full, while draining, or in reset; mem_ready=0 holds the head entry.
//
// Ports:
//   clk, rst                   single clock, synchronous active-high reset
//   req_valid/req_ready        store request handshake
//   req_base, req_imm          effective address operands (ea = base + imm)
//   req_data, req_func3        rs2 data and store width (000 SB, 001 SH, 010 SW)
//   mem_valid/mem_ready        write handshake towards data memory
//   mem_addr/wdata/wstrb       head entry: word address, lane-replicated data, byte enables
//   st_err                     one-cycle pulse after an illegal or misaligned store is accepted
//   fence_req/fence_done       level drain request and "drained" indication
//   count                      current queue occupancy
module store_queue_ctrl #(
    parameter int DEPTH = 4  // power of 2, at least 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_base,
    input  logic [31:0]              req_imm,
    input  logic [31:0]              req_data,
    input  logic [2:0]               req_func3,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_wstrb,
    output logic                     st_err,
    input  logic                     fence_req,
    output logic                     fence_done,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          err_q;

    logic [31:0]   q_addr  [DEPTH];
    logic [31:0]   q_wdata [DEPTH];
    logic [3:0]    q_wstrb [DEPTH];

    logic [31:0]   ea;
    logic          legal;
    logic [31:0]   enq_wdata;
    logic [3:0]    enq_wstrb;
    logic          accept;
    logic          push;
    logic          pop;

    // count never exceeds DEPTH, so its MSB is set exactly when the queue is full.
    // rst gates readiness so no store is taken while reset is held.
    assign req_ready = !rst && !count[AW] && (state == ST_RUN);
    assign accept    = req_valid && req_ready;
    assign push      = accept && legal;

    assign mem_valid = (count != '0);
    assign pop       = mem_valid && mem_ready;

    // Head outputs are forced to zero when empty so stale storage never leaks out.
    assign mem_addr  = mem_valid ? q_addr[rd_ptr]  : '0;
    assign mem_wdata = mem_valid ? q_wdata[rd_ptr] : '0;
    assign mem_wstrb = mem_valid ? q_wstrb[rd_ptr] : '0;

    assign st_err     = err_q;
    assign fence_done = (state == ST_DRAIN) && (count == '0);

    always_comb begin
        ea        = req_base + req_imm;
        legal     = 1'b0;
        enq_wdata = '0;
        enq_wstrb = '0;
        case (req_func3)
            3'b000: begin
                legal     = 1'b1;
                enq_wdata = {4{req_data[7:0]}};
                enq_wstrb = 4'b0001 << ea[1:0];
            end
            3'b001: begin
                legal     = !ea[0];
                enq_wdata = {2{req_data[15:0]}};
                enq_wstrb = 4'b0011 << ea[1:0];
            end
            3'b010: begin
                legal     = (ea[1:0] == 2'b00);
                enq_wdata = req_data;
                enq_wstrb = 4'b1111;
            end
            default: legal = 1'b0;
        endcase
    end

    // Payload storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr]  <= {ea[31:2], 2'b00};
            q_wdata[wr_ptr] <= enq_wdata;
            q_wstrb[wr_ptr] <= enq_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_RUN;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            err_q <= accept && !legal;
            case (state)
                ST_RUN:   if (fence_req)  state <= ST_DRAIN;
                ST_DRAIN: if (!fence_req) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_store_queue_ctrl.sv
module tb_store_queue_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_base;
    logic [31:0] req_imm;
    logic [31:0] req_data;
    logic [2:0]  req_func3;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        st_err;
    logic        fence_req;
    logic        fence_done;
    logic [2:0]  count;

    store_queue_ctrl #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_base   (req_base),
        .req_imm    (req_imm),
        .req_data   (req_data),
        .req_func3  (req_func3),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .st_err     (st_err),
        .fence_req  (fence_req),
        .fence_done (fence_done),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Expected memory writes as {addr, wdata, wstrb}; expected st_err pulses as a count.
    logic [67:0] sb[$];
    int          err_pending = 0;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one store for exactly one cycle; caller guarantees req_ready.
    task automatic send(input logic [31:0] b, input logic [31:0] i, input logic [31:0] d,
                        input logic [2:0] f, input bit is_err,
                        input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic [3:0] e_wstrb);
        if (is_err) err_pending++;
        else        sb.push_back({e_addr, e_wdata, e_wstrb});
        req_base  = b;
        req_imm   = i;
        req_data  = d;
        req_func3 = f;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Monitor: compares every memory write and every st_err pulse against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_valid && mem_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", {mem_addr, mem_wdata, mem_wstrb}, 68'h0);
                end else begin
                    logic [67:0] e;
                    e = sb.pop_front();
                    chk("mem_addr",  {36'h0, mem_addr},  {36'h0, e[67:36]});
                    chk("mem_wdata", {36'h0, mem_wdata}, {36'h0, e[35:4]});
                    chk("mem_wstrb", {64'h0, mem_wstrb}, {64'h0, e[3:0]});
                end
            end
            if (st_err) begin
                chk("st_err_expected", (err_pending > 0), 1);
                if (err_pending > 0) err_pending--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_base  = '0;
        req_imm   = '0;
        req_data  = '0;
        req_func3 = '0;
        mem_ready = 1'b0;
        fence_req = 1'b0;

        // Reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_req_ready",  req_ready,  0);
        chk("rst_mem_valid",  mem_valid,  0);
        chk("rst_count",      count,      0);
        chk("rst_fence_done", fence_done, 0);
        chk("rst_st_err",     st_err,     0);
        chk("rst_mem_out",    {mem_addr, mem_wdata, mem_wstrb}, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);

        // SB: ea=0x1003 -> lane 3
        tick();
        send(32'h1000, 32'd3, 32'hAABBCCDD, 3'b000, 0, 32'h1000, 32'hDDDDDDDD, 4'b1000);
        @(negedge clk);
        chk("sb_latency_valid", mem_valid, 1);
        chk("sb_count",         count,     1);
        chk("sb_wdata_direct",  mem_wdata, 32'hDDDDDDDD);
        tick();
        @(negedge clk);
        chk("stall_addr_stable", mem_addr,  32'h1000);
        chk("stall_strb_stable", mem_wstrb, 4'b1000);
        tick();
        mem_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("sb_drained_count", count,    0);
        chk("empty_mem_addr",   mem_addr, 0);

        // SH: ea=0x1FFE -> word 0x1FFC, upper half
        tick();
        send(32'h2000, 32'hFFFFFFFE, 32'h12345678, 3'b001, 0, 32'h1FFC, 32'h56785678, 4'b1100);
        tick();
        @(negedge clk);
        chk("sh_count", count, 0);

        // Errors: misaligned SW, illegal func3, misaligned SH
        tick();
        send(32'h1000, 32'd2, 32'h0, 3'b010, 1, 0, 0, 0);
        @(negedge clk);
        chk("err_sw_count", count,     0);
        chk("err_sw_valid", mem_valid, 0);
        tick();
        @(negedge clk);
        chk("err_pulse_one_cycle", st_err, 0);
        tick();
        send(32'h3000, 32'd0, 32'h0, 3'b011, 1, 0, 0, 0);
        @(negedge clk);
        chk("err_f3_count", count, 0);
        tick();
        send(32'h1001, 32'd0, 32'hFFFF, 3'b001, 1, 0, 0, 0);
        @(negedge clk);
        chk("err_sh_valid", mem_valid, 0);

        // Simultaneous push and pop keeps count unchanged
        tick();
        send(32'h40, 32'd0, 32'h11111111, 3'b010, 0, 32'h40, 32'h11111111, 4'b1111);
        send(32'h44, 32'd0, 32'h22222222, 3'b010, 0, 32'h44, 32'h22222222, 4'b1111);
        @(negedge clk);
        chk("push_pop_count", count, 1);
        tick();
        @(negedge clk);
        chk("push_pop_drain", count, 0);

        // Full queue with mem_ready held low; pointers wrap
        tick();
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            send(32'h100 + 32'(4*k), 32'd0, 32'hA0000000 + 32'(k), 3'b010, 0,
                 32'h100 + 32'(4*k), 32'hA0000000 + 32'(k), 4'b1111);
        @(negedge clk);
        chk("full_count", count,     4);
        chk("full_ready", req_ready, 0);
        tick();
        req_base  = 32'h110;
        req_imm   = 32'd0;
        req_data  = 32'hDEAD;
        req_func3 = 3'b010;
        req_valid = 1'b1;
        tick(); tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("full_blocked_count", count, 4);
        tick();
        mem_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("full_drained_count", count,     0);
        chk("full_ready_back",    req_ready, 1);

        // Fence: third store handshakes in the cycle fence_req rises
        tick();
        mem_ready = 1'b0;
        send(32'h200, 32'd0, 32'hB0, 3'b010, 0, 32'h200, 32'hB0, 4'b1111);
        send(32'h204, 32'd0, 32'hB1, 3'b010, 0, 32'h204, 32'hB1, 4'b1111);
        fence_req = 1'b1;
        send(32'h208, 32'd0, 32'hB2, 3'b010, 0, 32'h208, 32'hB2, 4'b1111);
        @(negedge clk);
        chk("fence_count",      count,      3);
        chk("fence_ready_low",  req_ready,  0);
        chk("fence_done_early", fence_done, 0);
        tick();
        mem_ready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk("fence_mid_done", fence_done, 0);
        tick();
        @(negedge clk);
        chk("fence_done", fence_done, 1);
        tick();
        fence_req = 1'b0;
        tick();
        @(negedge clk);
        chk("fence_exit_ready", req_ready,  1);
        chk("fence_exit_done",  fence_done, 0);

        // Fence aborted with an entry still queued
        tick();
        mem_ready = 1'b0;
        send(32'h300, 32'd0, 32'hC0, 3'b010, 0, 32'h300, 32'hC0, 4'b1111);
        fence_req = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("abort_ready_low", req_ready,  0);
        chk("abort_not_done",  fence_done, 0);
        tick();
        fence_req = 1'b0;
        tick();
        @(negedge clk);
        chk("abort_ready", req_ready, 1);
        chk("abort_count", count,     1);
        tick();
        mem_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("abort_drained", count, 0);

        // Reset mid-operation discards stalled entries
        tick();
        mem_ready = 1'b0;
        send(32'h400, 32'd0, 32'hD0, 3'b010, 0, 32'h400, 32'hD0, 4'b1111);
        send(32'h404, 32'd0, 32'hD1, 3'b010, 0, 32'h404, 32'hD1, 4'b1111);
        @(negedge clk);
        chk("pre_rst_count", count, 2);
        tick();
        rst = 1'b1;
        sb.delete();
        tick();
        @(negedge clk);
        chk("mid_rst_count", count,     0);
        chk("mid_rst_valid", mem_valid, 0);
        chk("mid_rst_ready", req_ready, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_ready", req_ready, 1);
        chk("after_rst_valid", mem_valid, 0);
        tick();
        mem_ready = 1'b1;
        send(32'h500, 32'd1, 32'h0000EE77, 3'b000, 0, 32'h500, 32'h77777777, 4'b0010);
        tick();
        @(negedge clk);
        chk("after_rst_drained", count, 0);

        chk("sb_empty",  sb.size(),   0);
        chk("err_empty", err_pending, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_queue_ctrl.md
STORE_QUEUE_CTRL -- requirements
Module: store_queue_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have parameter DEPTH, default 4, setting the store-queue entries; the value SHALL be a power of 2 and at least 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port req_valid, input, 1 bit: pipeline presents a store.
REQ-006 Port req_ready, output, 1 bit: block can accept a store this cycle.
REQ-007 Port req_base, input, 32 bits: base register value.
REQ-008 Port req_imm, input, 32 bits: sign-extended offset.
REQ-009 Port req_data, input, 32 bits: rs2 store data.
REQ-010 Port req_func3, input, 3 bits: store width; 000 = SB, 001 = SH, 010 = SW.
REQ-011 Port mem_valid, output, 1 bit: a write is presented to data memory.
REQ-012 Port mem_ready, input, 1 bit: memory accepts the write.
REQ-013 Port mem_addr, output, 32 bits: word-aligned write address.
REQ-014 Port mem_wdata, output, 32 bits: lane-aligned write data.
REQ-015 Port mem_wstrb, output, 4 bits: byte enables; bit i SHALL cover byte lane i.
REQ-016 Port st_err, output, 1 bit: one-cycle pulse reporting an illegal func3 or a misaligned store.
REQ-017 Port fence_req, input, 1 bit: level request to drain the queue.
REQ-018 Port fence_done, output, 1 bit: the queue is empty under fence.
REQ-019 Port count, output, log2(DEPTH)+1 bits: current occupancy.

Function
REQ-020 A store SHALL be accepted in any cycle where req_valid=1 and req_ready=1.
REQ-021 Effective address ea SHALL equal req_base+req_imm, modulo 2^32, with carry discarded.
REQ-022 SB SHALL enqueue wdata={4{data[7:0]}} and wstrb=4'b0001<<ea[1:0].
REQ-023 SH SHALL enqueue wdata={2{data[15:0]}} and wstrb=4'b0011<<ea[1:0].
REQ-024 SW SHALL enqueue wdata=data and wstrb=4'b1111.
REQ-025 Every enqueued entry SHALL store addr={ea[31:2],2'b00}.
REQ-026 Misaligned stores SHALL be treated as errors: SH with ea[0]=1, or SW with ea[1:0]!=0.
REQ-027 An accepted store that is misaligned or has func3 outside {000,001,010} SHALL NOT be enqueued, and st_err SHALL be 1 in the following cycle only.
REQ-028 req_ready SHALL be (count<DEPTH) AND (state==RUN), computed from registered state only; a pop in the same cycle SHALL NOT free space for that cycle.
REQ-029 mem_valid SHALL be (count!=0).
REQ-030 While count!=0, mem_addr, mem_wdata and mem_wstrb SHALL reflect the head entry; while count=0 they SHALL all be 0.
REQ-031 While mem_valid=1 and mem_ready=0, the head entry and all mem_* outputs SHALL remain stable.
REQ-032 A pop SHALL occur when mem_valid=1 and mem_ready=1; the next entry, if any, SHALL appear in the following cycle.
REQ-033 Latency SHALL be one cycle: a store accepted into an empty queue in cycle N SHALL produce mem_valid=1 in cycle N+1.
REQ-034 Entries SHALL issue in strict FIFO order.
REQ-035 Read and write pointers SHALL wrap modulo DEPTH.
REQ-036 A simultaneous push and pop SHALL leave count unchanged; with count=0, a push SHALL NOT bypass to memory in the same cycle.
REQ-037 The state machine SHALL have two states, RUN and DRAIN, with reset state RUN.
REQ-038 The transition RUN->DRAIN SHALL occur when fence_req=1; a store handshaking in that same cycle SHALL still be accepted.
REQ-039 In DRAIN, req_ready SHALL be 0 and queued entries SHALL continue to issue.
REQ-040 fence_done SHALL be 1 exactly when state==DRAIN and count==0.
REQ-041 The transition DRAIN->RUN SHALL occur when fence_req=0, whether or not the queue is empty; deasserting fence_req early SHALL abort the fence with no loss of entries.

Reset
REQ-042 While rst=1, count, both pointers, mem_valid, mem_addr, mem_wdata, mem_wstrb, st_err and fence_done SHALL be 0, req_ready SHALL be 0, and state SHALL be RUN.
REQ-043 In the first cycle after rst falls, req_ready SHALL be 1.
REQ-044 A reset asserted mid-operation SHALL discard all queued entries, including a head entry stalled on mem_ready=0; no pending st_err SHALL survive reset.

Verification
REQ-045 Scenario SB: base=0x1000, imm=3, data=0xAABBCCDD, func3=000 SHALL yield, in the next cycle, mem_addr=0x1000, mem_wdata=0xDDDDDDDD and mem_wstrb=1000.
REQ-046 Scenario SH: base=0x2000, imm=-2, data=0x12345678, func3=001 SHALL yield mem_addr=0x1FFC, mem_wdata=0x56785678 and mem_wstrb=1100.
REQ-047 Scenario errors: SW with ea=0x1002, or func3=011, SHALL produce a one-cycle st_err pulse with count staying 0 and mem_valid staying 0.
REQ-048 Scenario full queue: holding mem_ready=0 and pushing 5 SW stores SHALL give req_ready=0 after the 4th; then raising mem_ready SHALL issue the 4 stores in order and restore req_ready=1.
REQ-049 Scenario fence: with 3 entries queued, raising fence_req SHALL drop req_ready, assert fence_done after the 3rd pop, and return the block to RUN with req_ready=1 once fence_req falls.
REQ-050 Scenario reset: asserting rst with 2 entries queued and mem_ready=0 SHALL give count=0 and mem_valid=0 in the next cycle.
